// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Package : seg7_pkg
//  Brief   : Shared 7-segment glyph type and active-high segment patterns
//            ({g,f,e,d,c,b,a}) used by the BCD scanner and its decoder.
//  Rev     : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // One glyph, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
  typedef logic [6:0] seg7_t;

  // Decimal digit glyphs 0..9.
  localparam seg7_t SEG7_LUT [0:9] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

  // Non-decimal codes show a dash; blanked digits show nothing.
  localparam seg7_t SEG7_DASH  = 7'b1000000;
  localparam seg7_t SEG7_BLANK = 7'b0000000;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module : bcd_to_seg7
//  Brief  : Combinational BCD to 7-segment decoder (active-high glyphs).
//           Codes 10..15 render as a dash; i_blank forces all segments off.
//  Rev    : 1.0  initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output seg7_t      o_seg
);

  // Blanking overrides the glyph; anything outside 0..9 becomes a dash.
  always_comb begin
    o_seg = SEG7_DASH;
    if (i_blank) begin
      o_seg = SEG7_BLANK;
    end else if (i_bcd <= 4'd9) begin
      o_seg = SEG7_LUT[i_bcd];
    end
  end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_seg7_scanner.sv
`default_nettype none
// ============================================================================
//  Module : bcd_seg7_scanner
//  Brief  : Multiplexed common-anode 7-segment driver. Scans one digit per
//           refresh slot with a leading all-off gap, snapshots the BCD and
//           decimal-point inputs once per frame, and blanks leading zeros.
//           All outputs are registered.
//  Rev    : 1.0  initial release
// ============================================================================
module bcd_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [4*NUM_DIGITS-1:0]       i_bcd_digits,
  input  logic [NUM_DIGITS-1:0]         i_dp_in,
  output logic [NUM_DIGITS-1:0]         o_anode,
  output logic [6:0]                    o_segments,
  output logic                          o_dp,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx
);

  localparam int c_PW = $clog2(REFRESH_DIV);
  localparam int c_IW = $clog2(NUM_DIGITS);

  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(REFRESH_DIV - 1);
  localparam logic [c_PW-1:0] c_BLANK     = c_PW'(BLANK_CYCLES);
  localparam logic [c_IW-1:0] c_IDX_MAX   = c_IW'(NUM_DIGITS - 1);
  // Polarity mask applied only at the output register.
  localparam logic            c_POL       = (SEG_ACTIVE_LOW != 0);
  localparam logic            c_LZ_EN     = (LZ_BLANK != 0);

  // Scan state
  logic [c_PW-1:0]         r_presc;
  logic [c_IW-1:0]         r_idx;
  logic                    r_running;   // enabled on the previous clock
  logic [4*NUM_DIGITS-1:0] r_snap_bcd;
  logic [NUM_DIGITS-1:0]   r_snap_dp;

  // Output registers (already in pin polarity)
  logic [NUM_DIGITS-1:0]   r_anode;
  seg7_t                   r_seg;
  logic                    r_dp;
  logic [c_IW-1:0]         r_idx_out;

  logic                    w_presc_tc;
  logic                    w_idx_tc;
  logic                    w_load_snap;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic                    w_upper_zero;
  logic [3:0]              w_cur_bcd;
  logic                    w_cur_dp;
  logic                    w_cur_blank;
  seg7_t                   w_cur_seg;
  logic [NUM_DIGITS-1:0]   w_anode_nxt;
  seg7_t                   w_seg_nxt;
  logic                    w_dp_nxt;

  assign w_presc_tc  = (r_presc == c_PRESC_MAX);
  assign w_idx_tc    = (r_idx == c_IDX_MAX);
  // A new frame starts on the wrap back to digit 0 or on the first enabled clock.
  assign w_load_snap = i_enable && (!r_running || (w_presc_tc && w_idx_tc));

  // Prescaler and digit index advance; disable parks the scan at digit 0.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_running <= 1'b0;
    end else if (!i_enable) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_running <= 1'b0;
    end else begin
      r_running <= 1'b1;
      if (w_presc_tc) begin
        r_presc <= '0;
        r_idx   <= w_idx_tc ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Frame snapshot of the digit and decimal-point inputs (prevents tearing).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_snap_bcd <= '0;
      r_snap_dp  <= '0;
    end else if (w_load_snap) begin
      r_snap_bcd <= i_bcd_digits;
      r_snap_dp  <= i_dp_in;
    end
  end

  // Leading-zero mask: digit k is blanked when it and everything above it is 0.
  always_comb begin
    w_lz_blank   = '0;
    w_upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_upper_zero  = w_upper_zero && (r_snap_bcd[4*k +: 4] == 4'd0);
      w_lz_blank[k] = c_LZ_EN && w_upper_zero;
    end
  end

  // Select the snapshot fields of the digit currently in its slot.
  always_comb begin
    w_cur_bcd   = 4'd0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == c_IW'(k)) begin
        w_cur_bcd   = r_snap_bcd[4*k +: 4];
        w_cur_dp    = r_snap_dp[k];
        w_cur_blank = w_lz_blank[k];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .i_bcd   (w_cur_bcd),
    .i_blank (w_cur_blank),
    .o_seg   (w_cur_seg)
  );

  // Slot shaping: dark gap first, then the selected anode unless the digit is blanked.
  always_comb begin
    w_anode_nxt = '0;
    w_seg_nxt   = SEG7_BLANK;
    w_dp_nxt    = 1'b0;
    if (r_presc >= c_BLANK) begin
      w_seg_nxt = w_cur_seg;
      w_dp_nxt  = w_cur_dp;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if ((r_idx == c_IW'(k)) && !w_cur_blank) begin
          w_anode_nxt[k] = 1'b1;
        end
      end
    end
  end

  // Output register with polarity applied; disable or reset forces everything dark.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_anode   <= {NUM_DIGITS{c_POL}};
      r_seg     <= {7{c_POL}};
      r_dp      <= c_POL;
      r_idx_out <= '0;
    end else if (!i_enable) begin
      r_anode   <= {NUM_DIGITS{c_POL}};
      r_seg     <= {7{c_POL}};
      r_dp      <= c_POL;
      r_idx_out <= '0;
    end else begin
      r_anode   <= w_anode_nxt ^ {NUM_DIGITS{c_POL}};
      r_seg     <= w_seg_nxt ^ {7{c_POL}};
      r_dp      <= w_dp_nxt ^ c_POL;
      r_idx_out <= r_idx;
    end
  end

  assign o_anode     = r_anode;
  assign o_segments  = r_seg;
  assign o_dp        = r_dp;
  assign o_digit_idx = r_idx_out;

endmodule : bcd_seg7_scanner
`default_nettype wire

// File: tb/tb_bcd_seg7_scanner.sv
`default_nettype none
// ============================================================================
//  Module : tb_bcd_seg7_scanner
//  Brief  : Self-checking bench for bcd_seg7_scanner (4 digits, 4-cycle slots,
//           1-cycle dark gap, active-low pins, leading-zero blanking).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_bcd_seg7_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BLK = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dpi = 4'h0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  idx;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: enabled-clock count since the scan (re)started
  // and the frame snapshot the display is currently showing.
  int          m_t;
  bit          m_run;
  logic [15:0] m_snap;
  logic [3:0]  m_snap_dp;

  // Expected pins for the most recent clock edge
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [1:0]  e_idx;
  bit          e_full;   // segments/dp meaningful (outside the dark gap)

  bcd_seg7_scanner #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (DIV),
    .BLANK_CYCLES   (BLK),
    .SEG_ACTIVE_LOW (1),
    .LZ_BLANK       (1)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_bcd_digits (bcd),
    .i_dp_in      (dpi),
    .o_anode      (anode),
    .o_segments   (seg),
    .o_dp         (dp),
    .o_digit_idx  (idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Active-low glyphs as seen on the pins, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph_al(input logic [3:0] d);
    case (d)
      4'd0: glyph_al = 7'b1000000;
      4'd1: glyph_al = 7'b1111001;
      4'd2: glyph_al = 7'b0100100;
      4'd3: glyph_al = 7'b0110000;
      4'd4: glyph_al = 7'b0011001;
      4'd5: glyph_al = 7'b0010010;
      4'd6: glyph_al = 7'b0000010;
      4'd7: glyph_al = 7'b1111000;
      4'd8: glyph_al = 7'b0000000;
      4'd9: glyph_al = 7'b0010000;
      default: glyph_al = 7'b0111111;
    endcase
  endfunction

  task automatic model_reset();
    m_t       = 0;
    m_run     = 1'b0;
    m_snap    = 16'h0000;
    m_snap_dp = 4'h0;
  endtask

  // Advance one clock and compute what the pins must show after it.
  task automatic cycle();
    int presc;
    int d;
    bit blanked;
    @(posedge clk);
    if (!en) begin
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0; e_full = 1'b1;
      m_t = 0; m_run = 1'b0;
    end else begin
      presc = m_t % DIV;
      d     = (m_t / DIV) % N;
      e_idx = 2'(d);
      if (presc < BLK) begin
        e_anode = 4'hF; e_full = 1'b0;
      end else begin
        blanked = (d > 0) && ((m_snap >> (4 * d)) == 16'h0000);
        e_anode = blanked ? 4'hF : ~(4'b0001 << d);
        e_seg   = blanked ? 7'h7F : glyph_al(4'((m_snap >> (4 * d)) & 16'hF));
        e_dp    = ~m_snap_dp[d];
        e_full  = 1'b1;
      end
      if (!m_run || ((m_t + 1) % (DIV * N)) == 0) begin
        m_snap    = bcd;
        m_snap_dp = dpi;
      end
      m_t++;
      m_run = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; bcd = 16'h0000; dpi = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (anode !== 4'hF) $display("FAIL reset_anode got %b exp 1111", anode); else n_pass++;
    n_total++; if (seg !== 7'h7F) $display("FAIL reset_seg got %b exp 1111111", seg); else n_pass++;
    n_total++; if (dp !== 1'b1) $display("FAIL reset_dp got %b exp 1", dp); else n_pass++;
    n_total++; if (idx !== 2'd0) $display("FAIL reset_idx got %0d exp 0", idx); else n_pass++;
    rst = 1'b0; en = 1'b1; bcd = 16'h5678; dpi = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_total++; if (anode !== e_anode) $display("FAIL pre_reset_anode got %b exp %b", anode, e_anode); else n_pass++;
    end
    // Assert reset away from the clock edge: outputs must go dark without a clock.
    #3 rst = 1'b1;
    #1;
    n_total++; if (anode !== 4'hF) $display("FAIL async_reset_anode got %b exp 1111", anode); else n_pass++;
    n_total++; if (seg !== 7'h7F) $display("FAIL async_reset_seg got %b exp 1111111", seg); else n_pass++;
    n_total++; if (dp !== 1'b1) $display("FAIL async_reset_dp got %b exp 1", dp); else n_pass++;
    n_total++; if (idx !== 2'd0) $display("FAIL async_reset_idx got %0d exp 0", idx); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * DIV; i++) begin
      cycle();
      n_total++; if (anode !== e_anode) $display("FAIL restart_anode c=%0d got %b exp %b", i, anode, e_anode); else n_pass++;
      n_total++; if (idx !== e_idx) $display("FAIL restart_idx c=%0d got %0d exp %0d", i, idx, e_idx); else n_pass++;
      if (e_full) begin
        n_total++; if (seg !== e_seg) $display("FAIL restart_seg c=%0d got %b exp %b", i, seg, e_seg); else n_pass++;
        n_total++; if (dp !== e_dp) $display("FAIL restart_dp c=%0d got %b exp %b", i, dp, e_dp); else n_pass++;
      end
    end
  endtask

  task automatic test_scan_1234();
    bcd = 16'h1234; dpi = 4'b0101;
    for (int i = 0; i < 3 * DIV * N; i++) begin
      cycle();
      n_total++; if (anode !== e_anode) $display("FAIL scan_anode c=%0d got %b exp %b", i, anode, e_anode); else n_pass++;
      n_total++; if (idx !== e_idx) $display("FAIL scan_idx c=%0d got %0d exp %0d", i, idx, e_idx); else n_pass++;
      if (e_full) begin
        n_total++; if (seg !== e_seg) $display("FAIL scan_seg c=%0d got %b exp %b", i, seg, e_seg); else n_pass++;
        n_total++; if (dp !== e_dp) $display("FAIL scan_dp c=%0d got %b exp %b", i, dp, e_dp); else n_pass++;
      end
    end
  endtask

  task automatic test_lz_blanking();
    logic [15:0] pats [3];
    pats[0] = 16'h0070; pats[1] = 16'h0000; pats[2] = 16'h00A5;
    for (int p = 0; p < 3; p++) begin
      bcd = pats[p]; dpi = 4'b1100;
      for (int i = 0; i < 2 * DIV * N; i++) begin
        cycle();
        n_total++; if (anode !== e_anode) $display("FAIL lz_anode pat=%h c=%0d got %b exp %b", pats[p], i, anode, e_anode); else n_pass++;
        if (e_full) begin
          n_total++; if (seg !== e_seg) $display("FAIL lz_seg pat=%h c=%0d got %b exp %b", pats[p], i, seg, e_seg); else n_pass++;
          n_total++; if (dp !== e_dp) $display("FAIL lz_dp pat=%h c=%0d got %b exp %b", pats[p], i, dp, e_dp); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_midframe();
    bcd = 16'h1111; dpi = 4'h0;
    for (int i = 0; i < DIV * N; i++) cycle();
    // Move into the slot of digit 1 before changing the inputs.
    for (int i = 0; i < 2 * DIV * N && ((m_t / DIV) % N) != 1; i++) cycle();
    bcd = 16'h2222;
    for (int i = 0; i < 2 * DIV * N; i++) begin
      cycle();
      n_total++; if (anode !== e_anode) $display("FAIL midframe_anode c=%0d got %b exp %b", i, anode, e_anode); else n_pass++;
      if (e_full) begin
        n_total++; if (seg !== e_seg) $display("FAIL midframe_seg c=%0d got %b exp %b", i, seg, e_seg); else n_pass++;
      end
    end
  endtask

  task automatic test_enable();
    bcd = 16'h9876; dpi = 4'b0010;
    for (int i = 0; i < DIV * N && (m_t % DIV) != 2; i++) cycle();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_total++; if (anode !== e_anode) $display("FAIL disable_anode c=%0d got %b exp %b", i, anode, e_anode); else n_pass++;
      n_total++; if (seg !== e_seg) $display("FAIL disable_seg c=%0d got %b exp %b", i, seg, e_seg); else n_pass++;
      n_total++; if (dp !== e_dp) $display("FAIL disable_dp c=%0d got %b exp %b", i, dp, e_dp); else n_pass++;
      n_total++; if (idx !== e_idx) $display("FAIL disable_idx c=%0d got %0d exp %0d", i, idx, e_idx); else n_pass++;
    end
    en = 1'b1; bcd = 16'h4321;
    for (int i = 0; i < DIV * N + 2; i++) begin
      cycle();
      n_total++; if (anode !== e_anode) $display("FAIL reenable_anode c=%0d got %b exp %b", i, anode, e_anode); else n_pass++;
      n_total++; if (idx !== e_idx) $display("FAIL reenable_idx c=%0d got %0d exp %0d", i, idx, e_idx); else n_pass++;
      if (e_full) begin
        n_total++; if (seg !== e_seg) $display("FAIL reenable_seg c=%0d got %b exp %b", i, seg, e_seg); else n_pass++;
        n_total++; if (dp !== e_dp) $display("FAIL reenable_dp c=%0d got %b exp %b", i, dp, e_dp); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int nz;
    int off_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (off_left > 0) begin
        off_left--;
        en = (off_left == 0);
      end else if ($urandom_range(0, 59) == 0) begin
        off_left = $urandom_range(1, 3);
        en = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) begin
        nz  = $urandom_range(0, 4);
        bcd = 16'($urandom) & 16'((32'h1 << (4 * nz)) - 1);
        dpi = 4'($urandom);
      end
      cycle();
      n_total++; if (anode !== e_anode) $display("FAIL rand_anode c=%0d got %b exp %b", i, anode, e_anode); else n_pass++;
      n_total++; if (idx !== e_idx) $display("FAIL rand_idx c=%0d got %0d exp %0d", i, idx, e_idx); else n_pass++;
      if (e_full) begin
        n_total++; if (seg !== e_seg) $display("FAIL rand_seg c=%0d got %b exp %b", i, seg, e_seg); else n_pass++;
        n_total++; if (dp !== e_dp) $display("FAIL rand_dp c=%0d got %b exp %b", i, dp, e_dp); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_lz_blanking();
    test_midframe();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_bcd_seg7_scanner
`default_nettype wire
